ad_dec: RTL and testbench
=========================

Name: ad_dec

Overview:
- Downstream of the AD serial-to-parallel stage: consumes its 16-bit unsigned samples (ad_data/ad_vld) on clk_sys.
- Boxcar-averages blocks of 2^cfg_shift samples and truncates each block to a 16-bit mean.
- Buffers the means in a first-word-fall-through FIFO read with a valid/ready handshake by the packing/fx readout logic.
- Flags FIFO overflow with a sticky bit.

Parameters:
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW = 16 words.
- ACC_W, 23, accumulator width; must be at least 16 + 7.

Ports:
- clk_sys  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- ad_data  in  16  unsigned ADC sample; valid only while ad_vld is high.
- ad_vld  in  1  one-cycle sample strobe; the minimum spacing is 1 cycle.
- cfg_en  in  1  enables accumulation; when low, the accumulator is held cleared.
- cfg_shift  in  3  block length N = 2^cfg_shift (1..128).
- cfg_clr  in  1  one-cycle pulse that clears ovf.
- dec_data  out  16  FIFO head word.
- dec_vld  out  1  FIFO not empty; dec_data is valid.
- dec_rdy  in  1  consumer accepts the head word when dec_vld and dec_rdy are both high.
- fifo_cnt  out  FIFO_AW+1  number of words stored (0..16).
- ovf  out  1  sticky: a finished mean was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst_n=0) clears:
  - state to IDLE;
  - accumulator (acc) and sample counter (cnt);
  - FIFO read and write pointers;
  - fifo_cnt=0, dec_vld=0, dec_data=0, ovf=0.
- Accumulator FSM:
  - IDLE: acc=0, cnt=0.
    - If cfg_en=1, latch cfg_shift into shift_q and go to ACC.
    - ad_vld in the IDLE cycle itself is ignored.
  - ACC, each ad_vld: acc<=acc+ad_data (zero-extended to ACC_W), cnt<=cnt+1.
  - ACC, when ad_vld arrives with cnt==2^shift_q-1 (block end):
    - push_data = (acc+ad_data)>>shift_q, low 16 bits; truncation, no rounding;
    - assert push for exactly one cycle, registered in the next cycle;
    - acc<=0, cnt<=0, re-latch cfg_shift into shift_q.
  - cfg_shift changes during a block do not affect the current block.
  - cfg_en=0 in any state: next state IDLE; the partial block is discarded with no push. FIFO contents are kept and stay drainable.
  - shift_q=0: every ad_vld produces a push and the mean equals the sample.
  - Maximum sum is 128*65535 = 8388480, which fits in 23 bits with no overflow.
- Latency:
  - Block-end ad_vld at cycle T gives push at T+1.
  - If the FIFO was empty: dec_vld=1 and dec_data valid at T+2.
- FIFO (FWFT, registered head):
  - Pop occurs when dec_vld and dec_rdy are both high. The next word, or dec_vld=0, appears in the following cycle.
  - Push while fifo_cnt<16: the word is written.
  - Push while fifo_cnt==16 with a pop in the same cycle: the push is accepted and the count stays 16.
  - Push while fifo_cnt==16 with no pop: the word is dropped and ovf<=1. The FIFO contents are unchanged.
  - Pointers wrap modulo 16; fifo_cnt distinguishes full from empty.
  - Push and pop together with fifo_cnt==0 cannot occur, because dec_vld=0.
  - dec_rdy with dec_vld=0 has no effect.
  - dec_data holds its last value when dec_vld=0.
- ovf:
  - Set by a dropped push; cleared by cfg_clr.
  - If cfg_clr and a drop occur in the same cycle, set wins (ovf=1).
- There is no backpressure toward ad_s2p. Samples are never stalled, only averaged or dropped as whole means.

Test Plan:
- Reset mid-block: cfg_shift=2, cfg_en=1, send 2 samples, pulse rst_n low -> all outputs 0. Then 4 samples of 100 -> exactly one word of 100.
- Averaging/truncation: cfg_shift=2, samples 1,2,3,5 -> dec_data=2 (11>>2), dec_vld rises 2 cycles after the 4th ad_vld. cfg_shift=7 with 128×0xFFFF -> 0xFFFF.
- Bypass and back-to-back: cfg_shift=0, ad_vld every cycle with 0x0010..0x0013, dec_rdy=1 -> outputs 0x0010..0x0013 in order, one per cycle, fifo_cnt ≤2.
- Overflow: cfg_shift=0, dec_rdy=0, 17 samples 0..16 -> fifo_cnt=16, ovf=1. Drain yields 0..15; 16 is absent. cfg_clr pulse -> ovf=0. cfg_clr coincident with another drop -> ovf stays 1.
- Full with simultaneous pop: FIFO full, push and pop in the same cycle -> fifo_cnt stays 16, ovf stays 0, the new word appears last on drain.
- Config change: cfg_shift changed from 1 to 3 mid-block -> current block averages 2 samples, the next averages 8. cfg_en dropped mid-block -> no push, FIFO words remain readable.

Source files
------------

// File: rtl/ad_dec.sv
// Boxcar decimator: averages blocks of 2^cfg_shift ADC samples and queues the
// truncated 16-bit means in a first-word-fall-through FIFO with sticky overflow.
module ad_dec #(
  parameter int FIFO_AW = 4,
  parameter int ACC_W   = 23
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic [15:0]        ad_data,
  input  logic               ad_vld,
  input  logic               cfg_en,
  input  logic [2:0]         cfg_shift,
  input  logic               cfg_clr,
  output logic [15:0]        dec_data,
  output logic               dec_vld,
  input  logic               dec_rdy,
  output logic [FIFO_AW:0]   fifo_cnt,
  output logic               ovf
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  typedef enum logic {IDLE, ACC} state_t;

  typedef struct packed {
    logic        vld;
    logic [15:0] data;
  } push_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, acc_sum;
  logic [6:0]       cnt, cnt_nxt, blk_last;
  logic [2:0]       shift_q, shift_nxt;
  push_t            push, push_nxt;

  assign acc_sum  = acc + ACC_W'(ad_data);
  // Index of the last sample in a block: 2^shift_q - 1.
  assign blk_last = ~(7'h7f << shift_q);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      shift_q <= '0;
      push    <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      shift_q <= shift_nxt;
      push    <= push_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    shift_nxt     = shift_q;
    push_nxt.vld  = 1'b0;
    push_nxt.data = push.data;
    case (state)
      IDLE: begin
        acc_nxt = '0;
        cnt_nxt = '0;
        if (cfg_en) begin
          state_nxt = ACC;
          shift_nxt = cfg_shift;
        end
      end
      ACC: begin
        if (!cfg_en) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end else if (ad_vld) begin
          if (cnt == blk_last) begin
            push_nxt.vld  = 1'b1;
            push_nxt.data = 16'(acc_sum >> shift_q);
            acc_nxt       = '0;
            cnt_nxt       = '0;
            shift_nxt     = cfg_shift;
          end else begin
            acc_nxt = acc_sum;
            cnt_nxt = cnt + 7'd1;
          end
        end
      end
    endcase
  end

  // FIFO with a registered head word.
  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]      cnt_after;
  logic [15:0]        head_nxt;
  logic               full, pop, wr_en, drop;

  assign dec_vld    = (fifo_cnt != '0);
  assign full       = (fifo_cnt == CW'(DEPTH));
  assign pop        = dec_vld && dec_rdy;
  assign wr_en      = push.vld && (!full || pop);
  assign drop       = push.vld && full && !pop;
  assign rd_ptr_nxt = rd_ptr + FIFO_AW'(pop);
  assign cnt_after  = fifo_cnt + CW'(wr_en) - CW'(pop);
  // When nothing else survives the pop, the incoming word becomes the head directly.
  assign head_nxt   = (wr_en && (fifo_cnt == CW'(pop))) ? push.data : mem[rd_ptr_nxt];

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr] <= push.data;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      dec_data <= '0;
      ovf      <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
      rd_ptr   <= rd_ptr_nxt;
      fifo_cnt <= cnt_after;
      if (cnt_after != '0) dec_data <= head_nxt;
      if (drop)         ovf <= 1'b1;
      else if (cfg_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad_dec.sv
// Bench for ad_dec: directed scenarios plus random traffic, scored against a
// sample-list averaging model and a queue model of the output FIFO.
module tb_ad_dec;

  logic        clk_sys, rst_n;
  logic [15:0] ad_data;
  logic        ad_vld, cfg_en, cfg_clr, dec_rdy;
  logic [2:0]  cfg_shift;
  logic [15:0] dec_data;
  logic        dec_vld, ovf;
  logic [4:0]  fifo_cnt;

  ad_dec #(.FIFO_AW(4), .ACC_W(23)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .ad_data(ad_data), .ad_vld(ad_vld),
    .cfg_en(cfg_en), .cfg_shift(cfg_shift), .cfg_clr(cfg_clr),
    .dec_data(dec_data), .dec_vld(dec_vld), .dec_rdy(dec_rdy),
    .fifo_cnt(fifo_cnt), .ovf(ovf)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] mean;
  } gen_t;

  // Driver-owned: finished means tagged with the cycle of their last sample.
  gen_t        gen_q[$];
  logic [15:0] blk[$];
  bit          m_act;
  int          m_shift;

  // Monitor-owned scoreboard state.
  logic [15:0] exp_q[$];
  logic [15:0] last_head;
  logic        ovf_exp;
  int          gen_rd;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    bit          pop, push, drop;
    logic [15:0] pdata;
    if (!rst_n) begin
      chk("rst_dec_vld", 32'(dec_vld), 0);
      chk("rst_dec_data", 32'(dec_data), 0);
      chk("rst_fifo_cnt", 32'(fifo_cnt), 0);
      chk("rst_ovf", 32'(ovf), 0);
      exp_q.delete();
      ovf_exp   = 1'b0;
      last_head = '0;
      gen_rd    = gen_q.size();
    end else begin
      chk("dec_vld", 32'(dec_vld), 32'(exp_q.size() != 0));
      chk("fifo_cnt", 32'(fifo_cnt), exp_q.size());
      chk("ovf", 32'(ovf), 32'(ovf_exp));
      if (exp_q.size() != 0) begin
        last_head = exp_q[0];
        chk("dec_data", 32'(dec_data), 32'(exp_q[0]));
      end else begin
        chk("dec_data_hold", 32'(dec_data), 32'(last_head));
      end
      pop  = (exp_q.size() != 0) && dec_rdy;
      push = 1'b0;
      pdata = '0;
      while (gen_rd < gen_q.size() && gen_q[gen_rd].cyc < cyc - 1) gen_rd++;
      if (gen_rd < gen_q.size() && gen_q[gen_rd].cyc == cyc - 1) begin
        push  = 1'b1;
        pdata = gen_q[gen_rd].mean;
        gen_rd++;
      end
      drop = push && (exp_q.size() == 16) && !pop;
      if (pop) void'(exp_q.pop_front());
      if (push && !drop) exp_q.push_back(pdata);
      if (drop) ovf_exp = 1'b1;
      else if (cfg_clr) ovf_exp = 1'b0;
    end
  end

  // Averaging model: collect whole blocks of samples, emit their truncated mean.
  task automatic model_step();
    int sum;
    if (!rst_n) begin
      m_act = 1'b0;
      blk.delete();
    end else if (!m_act) begin
      if (cfg_en) begin
        m_act   = 1'b1;
        m_shift = int'(cfg_shift);
      end
    end else if (!cfg_en) begin
      m_act = 1'b0;
      blk.delete();
    end else if (ad_vld) begin
      blk.push_back(ad_data);
      if (blk.size() == (1 << m_shift)) begin
        sum = 0;
        foreach (blk[i]) sum += int'(blk[i]);
        gen_q.push_back('{cyc: cyc, mean: 16'(sum >> m_shift)});
        blk.delete();
        m_shift = int'(cfg_shift);
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic samp(input logic [15:0] d);
    ad_vld  = 1'b1;
    ad_data = d;
    step();
    ad_vld  = 1'b0;
  endtask

  task automatic restart(input logic [2:0] s);
    cfg_en = 1'b0;
    step();
    cfg_shift = s;
    cfg_en    = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; ad_data = '0; ad_vld = 1'b0; cfg_en = 1'b0;
    cfg_shift = '0; cfg_clr = 1'b0; dec_rdy = 1'b0;
    m_act = 1'b0; m_shift = 0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Reset in the middle of a block, then one clean block of 100s.
    cfg_shift = 3'd2; cfg_en = 1'b1;
    idle(1);
    samp(16'd7); samp(16'd9);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    repeat (4) samp(16'd100);
    idle(3);
    dec_rdy = 1'b1;
    idle(3);

    // Truncating average, then the widest block at full scale.
    samp(16'd1); samp(16'd2); samp(16'd3); samp(16'd5);
    idle(4);
    restart(3'd7);
    repeat (128) samp(16'hffff);
    idle(4);

    // Bypass block length, back-to-back samples.
    restart(3'd0);
    for (int i = 0; i < 4; i++) samp(16'h0010 + 16'(i));
    idle(4);

    // Overflow, clear, clear coinciding with a drop, drain.
    dec_rdy = 1'b0;
    for (int i = 0; i <= 16; i++) samp(16'(i));
    idle(2);
    cfg_clr = 1'b1; step(); cfg_clr = 1'b0;
    idle(1);
    samp(16'd99);
    cfg_clr = 1'b1; step(); cfg_clr = 1'b0;
    idle(1);
    dec_rdy = 1'b1;
    idle(20);

    // Full FIFO with push and pop in the same cycle.
    dec_rdy = 1'b0;
    restart(3'd7);
    cfg_clr = 1'b1; step(); cfg_clr = 1'b0;
    restart(3'd0);
    for (int i = 0; i < 16; i++) samp(16'h0200 + 16'(i));
    idle(1);
    samp(16'h03aa);
    dec_rdy = 1'b1; step(); dec_rdy = 1'b0;
    idle(2);
    dec_rdy = 1'b1;
    idle(20);

    // Block length change mid-block, then enable dropped mid-block.
    restart(3'd1);
    samp(16'd10);
    cfg_shift = 3'd3;
    samp(16'd21);
    for (int i = 0; i < 8; i++) samp(16'(i * 7 + 3));
    idle(3);
    dec_rdy = 1'b0;
    for (int i = 0; i < 8; i++) samp(16'(i + 50));
    samp(16'd1); samp(16'd2); samp(16'd3);
    cfg_en = 1'b0;
    idle(4);
    dec_rdy = 1'b1;
    idle(6);

    // Random traffic with bursts of backpressure and one reset.
    cfg_en = 1'b1; cfg_shift = 3'd1;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
      end
      ad_vld  = 1'($urandom_range(0, 1));
      ad_data = 16'($urandom);
      dec_rdy = ((i / 250) % 2 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
      cfg_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) cfg_shift = 3'($urandom_range(0, 3));
      cfg_en  = ($urandom_range(0, 299) != 0);
      step();
    end
    ad_vld = 1'b0; cfg_clr = 1'b0; cfg_en = 1'b0; dec_rdy = 1'b1;
    idle(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
